// File: rtl/atm_txn_controller.sv
`timescale 1ns/1ps
// atm_txn_controller
//   Transaction sequencer for the ATM balance datapath. Turns debounced
//   deposit/withdraw button levels into exactly one validated,
//   saturation-checked balance update per press.
//
//   Optional feature macro: ATM_WD_LIMIT_EN
//     defined   - cumulative withdrawal total since reset is tracked and any
//                 withdrawal that would push it past WD_LIMIT is rejected.
//     undefined - withdrawals are limited only by the balance.
//
// Ports
//   clk       in   1      system clock
//   reset     in   1      asynchronous active-low reset
//   dep_req   in   1      debounced deposit button level
//   wd_req    in   1      debounced withdraw button level
//   sw        in   6      one-hot bill select: $1,$5,$10,$20,$50,$100
//   balance   out  WIDTH  committed balance
//   busy      out  1      high whenever the FSM is not IDLE
//   led_bill  out  1      invalid bill selection
//   led_ovf   out  1      deposit rejected (would overflow)
//   led_unf   out  1      withdrawal rejected (funds or limit)
module atm_txn_controller #(
    parameter int WIDTH    = 8,
    parameter int ERR_HOLD = 50_000_000,
    parameter int WD_LIMIT = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dep_req,
    input  logic             wd_req,
    input  logic [5:0]       sw,
    output logic [WIDTH-1:0] balance,
    output logic             busy,
    output logic             led_bill,
    output logic             led_ovf,
    output logic             led_unf
);

    localparam int TW = $clog2(ERR_HOLD + 1);
    localparam logic [TW-1:0] HOLD = TW'(ERR_HOLD);

    // Elaboration-time sanity check on the configuration.
    if (ERR_HOLD < 1 || WD_LIMIT < 0) begin : g_bad_param
        $error("atm_txn_controller: ERR_HOLD must be >= 1 and WD_LIMIT >= 0");
    end

    typedef enum logic [2:0] {IDLE, CHECK, COMMIT, ERROR, RELEASE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_dep_lvl, r_dep_prev, r_wd_lvl, r_wd_prev;
    logic              r_op_wd;
    logic [WIDTH:0]    r_bill;
    logic [2:0]        r_err;     // {unf, ovf, bill}
    logic [2:0]        r_led;     // {unf, ovf, bill}
    logic [TW-1:0]     r_timer;
    logic [WIDTH-1:0]  r_balance;

    logic              w_dep_rise, w_wd_rise;
    logic [WIDTH:0]    w_bill;
    logic              w_bill_ok;
    logic [WIDTH:0]    w_dep_sum;
    logic              w_over_limit;
    logic [2:0]        w_err;

    // Two-stage edge detect: the first stage is the registered copy of the
    // level, the second its previous value. This places the CHECK decision
    // two edges after the press is sampled and the commit on the third.
    assign w_dep_rise = r_dep_lvl & ~r_dep_prev;
    assign w_wd_rise  = r_wd_lvl  & ~r_wd_prev;

    always_comb begin
        w_bill    = '0;
        w_bill_ok = 1'b1;
        case (sw)
            6'b000001: w_bill = (WIDTH+1)'(1);
            6'b000010: w_bill = (WIDTH+1)'(5);
            6'b000100: w_bill = (WIDTH+1)'(10);
            6'b001000: w_bill = (WIDTH+1)'(20);
            6'b010000: w_bill = (WIDTH+1)'(50);
            6'b100000: w_bill = (WIDTH+1)'(100);
            default:   w_bill_ok = 1'b0;
        endcase
    end

    // Carry out of the (WIDTH+1)-bit sum is exactly "exceeds 2**WIDTH-1".
    assign w_dep_sum = {1'b0, r_balance} + w_bill;

`ifdef ATM_WD_LIMIT_EN
    logic [WIDTH:0]   r_wd_total;
    logic [WIDTH+1:0] w_total_chk, w_total_cmt;
    assign w_total_chk  = {1'b0, r_wd_total} + {1'b0, w_bill};
    assign w_total_cmt  = {1'b0, r_wd_total} + {1'b0, r_bill};
    assign w_over_limit = (w_total_chk > (WIDTH+2)'(WD_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wd_total <= '0;
        else if (r_state == COMMIT && r_op_wd)
            r_wd_total <= w_total_cmt[WIDTH+1] ? '1 : w_total_cmt[WIDTH:0];
    end
`else
    assign w_over_limit = 1'b0;
`endif

    // Bill validity takes precedence; ovf/unf only apply to a valid bill.
    always_comb begin
        w_err = 3'b000;
        if (!w_bill_ok)
            w_err = 3'b001;
        else if (!r_op_wd && w_dep_sum[WIDTH])
            w_err = 3'b010;
        else if (r_op_wd && ((w_bill > {1'b0, r_balance}) || w_over_limit))
            w_err = 3'b100;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_dep_rise || w_wd_rise) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = (w_err != 3'b000) ? ERROR : COMMIT;
            COMMIT:  w_state_nxt = RELEASE;
            ERROR:   if (r_timer == HOLD) w_state_nxt = RELEASE;
            RELEASE: if (!dep_req && !wd_req) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dep_lvl  <= 1'b0;
            r_dep_prev <= 1'b0;
            r_wd_lvl   <= 1'b0;
            r_wd_prev  <= 1'b0;
            r_op_wd    <= 1'b0;
            r_bill     <= '0;
            r_err      <= 3'b000;
            r_led      <= 3'b000;
            r_timer    <= '0;
            r_balance  <= '0;
        end else begin
            r_dep_lvl  <= dep_req;
            r_dep_prev <= r_dep_lvl;
            r_wd_lvl   <= wd_req;
            r_wd_prev  <= r_wd_lvl;
            case (r_state)
                // Deposit wins a simultaneous rise.
                IDLE: if (w_dep_rise || w_wd_rise) r_op_wd <= ~w_dep_rise;
                // Bill is captured here so later switch changes are ignored.
                CHECK: begin
                    r_bill  <= w_bill;
                    r_err   <= w_err;
                    r_timer <= '0;
                end
                COMMIT: begin
                    if (r_op_wd) r_balance <= r_balance - r_bill[WIDTH-1:0];
                    else         r_balance <= r_balance + r_bill[WIDTH-1:0];
                end
                // LED lights on the first ERROR edge (where a commit would
                // have landed) and stays for ERR_HOLD cycles.
                ERROR: begin
                    if (r_timer == HOLD) begin
                        r_led   <= 3'b000;
                        r_timer <= '0;
                    end else begin
                        if (r_timer == '0) r_led <= r_err;
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign balance  = r_balance;
    assign busy     = (r_state != IDLE);
    assign led_bill = r_led[0];
    assign led_ovf  = r_led[1];
    assign led_unf  = r_led[2];

endmodule

// File: tb/tb_atm_txn_controller.sv
`timescale 1ns/1ps
// Directed bench for atm_txn_controller with ERR_HOLD=4.
module tb_atm_txn_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dep_req = 1'b0;
    logic       wd_req = 1'b0;
    logic [5:0] sw = 6'b0;
    logic [7:0] balance;
    logic       busy, led_bill, led_ovf, led_unf;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] B1 = 6'b000001, B5 = 6'b000010, B10 = 6'b000100,
                           B20 = 6'b001000, B50 = 6'b010000, B100 = 6'b100000;
    localparam logic [2:0] L_NONE = 3'b000, L_BILL = 3'b001, L_OVF = 3'b010,
                           L_UNF = 3'b100;

    atm_txn_controller #(.WIDTH(8), .ERR_HOLD(4), .WD_LIMIT(200)) dut (
        .clk(clk), .reset(reset), .dep_req(dep_req), .wd_req(wd_req), .sw(sw),
        .balance(balance), .busy(busy), .led_bill(led_bill), .led_ovf(led_ovf),
        .led_unf(led_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] leds();
        return {29'd0, led_unf, led_ovf, led_bill};
    endfunction

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            tick();
        end
        chk(tag, busy, 0);
    endtask

    task automatic do_reset();
        dep_req = 0; wd_req = 0; reset = 0;
        tick(); tick();
        reset = 1;
        tick();
    endtask

    // One press: E0 samples the level, E1 enters CHECK, E3 is commit/LED edge.
    task automatic txn(input string tag, input logic wd, input logic [5:0] s,
                       input logic [2:0] exp_led, input logic [7:0] exp_bal);
        sw = s;
        if (wd) wd_req = 1; else dep_req = 1;
        tick();                                   // E0
        tick();                                   // E1
        chk({tag, ".busy"}, busy, 1);
        tick();                                   // E2
        chk({tag, ".led_pre"}, leds(), 0);
        tick();                                   // E3
        chk({tag, ".led"}, leds(), {29'd0, exp_led});
        chk({tag, ".bal"}, balance, {24'd0, exp_bal});
        if (exp_led != L_NONE) begin
            repeat (3) tick();                    // E6, last lit cycle
            chk({tag, ".led_hold"}, leds(), {29'd0, exp_led});
            tick();                               // E7
            chk({tag, ".led_clr"}, leds(), 0);
        end
        dep_req = 0; wd_req = 0;
        wait_idle({tag, ".idle"});
        chk({tag, ".bal_end"}, balance, {24'd0, exp_bal});
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst.bal", balance, 0);
        chk("rst.busy", busy, 0);
        chk("rst.led", leds(), 0);
        reset = 1;
        tick();

        // 1: deposit $10, exact latency, held button does not repeat
        sw = B10; dep_req = 1;
        tick();                                   // E0
        chk("t1.busy_e0", busy, 0);
        tick();                                   // E1
        chk("t1.busy_e1", busy, 1);
        tick();                                   // E2
        chk("t1.bal_e2", balance, 0);
        tick();                                   // E3
        chk("t1.bal_e3", balance, 10);
        chk("t1.led", leds(), 0);
        repeat (20) tick();
        chk("t1.bal_hold", balance, 10);
        chk("t1.busy_hold", busy, 1);
        dep_req = 0;
        wait_idle("t1.idle");

        // 5a: simultaneous rises, deposit wins
        sw = B5; dep_req = 1; wd_req = 1;
        repeat (4) tick();
        chk("t5.both", balance, 15);
        dep_req = 0; wd_req = 0;
        wait_idle("t5.both_idle");

        // 5b: withdraw rise during busy is ignored
        sw = B1; dep_req = 1;
        tick(); tick();                           // E1, busy
        wd_req = 1;
        tick(); tick();                           // E3
        chk("t5.wd_busy", balance, 16);
        dep_req = 0; wd_req = 0;
        wait_idle("t5.wd_busy_idle");
        repeat (3) tick();
        chk("t5.wd_busy_after", balance, 16);

        // 5c: reset while in CHECK aborts the transaction
        sw = B5; dep_req = 1;
        tick(); tick();                           // E1 -> CHECK
        chk("t5.in_check", busy, 1);
        reset = 0; #1;
        chk("t5.rst_bal", balance, 0);
        chk("t5.rst_busy", busy, 0);
        chk("t5.rst_led", leds(), 0);
        dep_req = 0;
        tick();
        reset = 1;
        tick(); tick();
        chk("t5.rst_after", busy, 0);

        // 2: build to 200, +50, overflow reject, exact fit to 255
        txn("t2.d100a", 0, B100, L_NONE, 100);
        txn("t2.d100b", 0, B100, L_NONE, 200);
        txn("t2.d50",   0, B50,  L_NONE, 250);
        txn("t2.ovf",   0, B10,  L_OVF,  250);
        txn("t2.d5",    0, B5,   L_NONE, 255);

        // 6: withdrawals against the optional cumulative limit
        txn("t6.w100a", 1, B100, L_NONE, 155);
        txn("t6.w100b", 1, B100, L_NONE, 55);
`ifdef ATM_WD_LIMIT_EN
        txn("t6.w1",    1, B1,   L_UNF,  55);
`else
        txn("t6.w1",    1, B1,   L_NONE, 54);
`endif

        // 3: underflow reject then exact drain to 0
        do_reset();
        txn("t3.d20",  0, B20, L_NONE, 20);
        txn("t3.unf",  1, B50, L_UNF,  20);
        txn("t3.w20",  1, B20, L_NONE, 0);

        // 4: invalid bill selections
        txn("t4.d10",   0, B10,       L_NONE, 10);
        txn("t4.multi", 0, 6'b000011, L_BILL, 10);
        txn("t4.zero",  0, 6'b000000, L_BILL, 10);
        txn("t4.wmulti", 1, 6'b110000, L_BILL, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
